// File: rtl/cordic_angle_seq.sv
// cordic_angle_seq: phase sweep generator feeding the CORDIC rotator.
// Emits start, start+step, ... for n samples on a valid/ready handshake.
// Each phase is folded into [-pi/2, pi/2) with a flip flag for the consumer.
// Optional feature macro: CORDIC_SEQ_CONT_EN (n_samples=0 -> continuous sweep,
// stopped by a start pulse while running).
module cordic_angle_seq #(
  parameter int ANGLE_W = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ANGLE_W-1:0] z_start,
  input  logic [ANGLE_W-1:0] z_step,
  input  logic [COUNT_W-1:0] n_samples,
  output logic [ANGLE_W-1:0] z_out,
  output logic               flip,
  output logic               z_valid,
  input  logic               z_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [ANGLE_W-1:0] phase;
  logic [ANGLE_W-1:0] step;
  logic [COUNT_W-1:0] count;
  logic               xfer;
`ifdef CORDIC_SEQ_CONT_EN
  logic               cont;
`endif

  assign xfer    = (state == RUN) && z_ready;
  assign z_valid = (state == RUN);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  // Quadrants 01 and 10 are rotated by pi so the rotator always converges.
  assign flip  = phase[ANGLE_W-1] ^ phase[ANGLE_W-2];
  assign z_out = {phase[ANGLE_W-1] ^ flip, phase[ANGLE_W-2:0]};

  // State register; reset aborts any sweep without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: count-terminated sweep, optional continuous mode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef CORDIC_SEQ_CONT_EN
          state_nxt = RUN;
`else
          state_nxt = (n_samples == '0) ? DONE : RUN;
`endif
        end
      end
      RUN: begin
`ifdef CORDIC_SEQ_CONT_EN
        if (cont) begin
          if (start) state_nxt = DONE;
        end else if (xfer && count == COUNT_W'(1)) begin
          state_nxt = DONE;
        end
`else
        if (xfer && count == COUNT_W'(1)) state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep parameters are captured on an accepted start and advanced per transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
      step  <= '0;
      count <= '0;
`ifdef CORDIC_SEQ_CONT_EN
      cont  <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      phase <= z_start;
      step  <= z_step;
      count <= n_samples;
`ifdef CORDIC_SEQ_CONT_EN
      cont  <= (n_samples == '0);
`endif
    end else if (xfer) begin
      phase <= phase + step;
      count <= count - COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cordic_angle_seq.sv
// Testbench for cordic_angle_seq: directed and random sweeps checked
// against an arithmetic reference (sample i = fold(start + i*step)).
module tb_cordic_angle_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] z_start;
  logic [31:0] z_step;
  logic [15:0] n_samples;
  logic [31:0] z_out;
  logic        flip;
  logic        z_valid;
  logic        z_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  cordic_angle_seq #(.ANGLE_W(32), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .z_start(z_start),
    .z_step(z_step), .n_samples(n_samples), .z_out(z_out), .flip(flip),
    .z_valid(z_valid), .z_ready(z_ready), .busy(busy), .done(done)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference fold: quadrants 1 and 2 get pi added and the flip flag set.
  function automatic logic [32:0] ref_fold(input logic [31:0] p);
    int unsigned quad;
    quad = p / 32'h40000000;
    if (quad == 1 || quad == 2) return {1'b1, p + 32'h80000000};
    return {1'b0, p};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: 3-cycle stall on sample 2.
  // poke: pulse start with different inputs while running.
  task automatic run_sweep(input string tag, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input int mode, input bit poke);
    logic [32:0] e;
    int idx = 0;
    int cyc = 0;
    int stall_left = 3;
    int budget;
    budget = 4 * int'(n) + 50;
    @(negedge clk);
    z_start = s; z_step = d; n_samples = n; start = 1'b1;
    @(negedge clk);
    while (1) begin
      if (poke && cyc == 2) begin
        start = 1'b1; z_start = ~s; z_step = d + 32'h1; n_samples = n + 16'd3;
      end else begin
        start = 1'b0;
      end
      if (mode == 2 && idx == 2 && stall_left > 0) begin
        z_ready = 1'b0; stall_left--;
      end else if (mode == 1) begin
        z_ready = 1'($urandom_range(0, 1));
      end else begin
        z_ready = 1'b1;
      end
      e = ref_fold(s + 32'(idx) * d);
      check_output({tag, " valid"}, 32'(z_valid), 32'd1);
      check_output({tag, " busy"}, 32'(busy), 32'd1);
      check_output({tag, " z_out"}, z_out, e[31:0]);
      check_output({tag, " flip"}, 32'(flip), 32'(e[32]));
      if (z_ready) idx++;
      cyc++;
      if (idx == int'(n) || cyc > budget) break;
      @(negedge clk);
    end
    check_output({tag, " transfers"}, 32'(idx), 32'(n));
    @(negedge clk);
    start = 1'b0;
    check_output({tag, " done"}, 32'(done), 32'd1);
    check_output({tag, " valid_after"}, 32'(z_valid), 32'd0);
    check_output({tag, " busy_after"}, 32'(busy), 32'd0);
    @(negedge clk);
    check_output({tag, " done_clear"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [32:0] e;
    reset = 1'b0; start = 1'b0; z_start = '0; z_step = '0; n_samples = '0; z_ready = 1'b1;
    $display("[TB] reset state");
    @(negedge clk);
    check_output("rst z_out", z_out, 32'h0);
    check_output("rst flip", 32'(flip), 32'd0);
    check_output("rst valid", 32'(z_valid), 32'd0);
    check_output("rst busy", 32'(busy), 32'd0);
    check_output("rst done", 32'(done), 32'd0);
    reset = 1'b1;

    $display("[TB] quadrant fold");
    run_sweep("quad", 32'h0, 32'h40000000, 16'd4, 0, 1'b0);
    $display("[TB] backpressure");
    run_sweep("stall", 32'h0, 32'h40000000, 16'd4, 2, 1'b0);
    $display("[TB] wrap-around");
    run_sweep("wrap", 32'hF0000000, 32'h20000000, 16'd2, 0, 1'b0);
    $display("[TB] ignored start");
    run_sweep("poke", 32'h2000_0000, 32'h1300_0000, 16'd6, 0, 1'b1);
    $display("[TB] single sample");
    run_sweep("one", 32'h7FFF_FFFF, 32'h1, 16'd1, 1, 1'b0);

    $display("[TB] random sweeps");
    for (int r = 0; r < 6; r++) begin
      run_sweep("rand", $urandom, $urandom, 16'($urandom_range(1, 20)), 1, 1'b0);
    end

    $display("[TB] async reset mid-sweep");
    z_ready = 1'b1;
    @(negedge clk);
    z_start = 32'h12345678; z_step = 32'h01000000; n_samples = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e = ref_fold(32'h12345678 + 32'd2 * 32'h01000000);
    check_output("pre-rst z_out", z_out, e[31:0]);
    #2 reset = 1'b0;
    #1;
    check_output("mid-rst z_out", z_out, 32'h0);
    check_output("mid-rst flip", 32'(flip), 32'd0);
    check_output("mid-rst valid", 32'(z_valid), 32'd0);
    check_output("mid-rst busy", 32'(busy), 32'd0);
    check_output("mid-rst done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("post-rst done", 32'(done), 32'd0);
    check_output("post-rst valid", 32'(z_valid), 32'd0);
    run_sweep("fresh", 32'hC000_0000, 32'h3000_0000, 16'd5, 0, 1'b0);

`ifdef CORDIC_SEQ_CONT_EN
    $display("[TB] continuous mode");
    z_ready = 1'b1;
    @(negedge clk);
    z_start = 32'h0800_0000; z_step = 32'h0300_0001; n_samples = 16'd0; start = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      start = (i == 119);
      e = ref_fold(32'h0800_0000 + 32'(i) * 32'h0300_0001);
      check_output("cont valid", 32'(z_valid), 32'd1);
      check_output("cont z_out", z_out, e[31:0]);
      check_output("cont flip", 32'(flip), 32'(e[32]));
    end
    @(negedge clk);
    start = 1'b0;
    check_output("cont done", 32'(done), 32'd1);
    check_output("cont valid_after", 32'(z_valid), 32'd0);
    @(negedge clk);
    check_output("cont done_clear", 32'(done), 32'd0);
`else
    $display("[TB] zero count");
    @(negedge clk);
    z_start = 32'h5555_5555; z_step = 32'h1; n_samples = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("zero done", 32'(done), 32'd1);
    check_output("zero valid", 32'(z_valid), 32'd0);
    @(negedge clk);
    check_output("zero done_clear", 32'(done), 32'd0);
    check_output("zero valid2", 32'(z_valid), 32'd0);
`endif

    run_sweep("final", 32'h9000_0000, 32'hE000_0000, 16'd3, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
